// File: rtl/pc_redirect_sched.sv
// pc_redirect_sched: next-PC scheduler for the pipelined MIPS core.
// Picks between sequential PC+1 (word address), ID-stage jumps, EX-stage
// taken branches and (optionally) exceptions. It drives the PC register
// write enable and the pipeline flushes. A redirect that arrives while the
// PC write is blocked is held until the block clears.
//
// Optional feature macro: PC_SCHED_EXC_EN. When defined, exc_req takes top
// priority and redirects to EXC_PC. When undefined, exc_req is ignored and
// flush_ex is tied to 0.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   pc                current PC[31:2]
//   stall, imem_ready load-use stall / fetch accept (blocked = stall | ~imem_ready)
//   jmp_req/jmp_tgt   ID-stage jump and its target [31:2]
//   br_req/br_tgt     EX-stage taken branch and its target [31:2]
//   exc_req           exception request (only with PC_SCHED_EXC_EN)
//   pc_wr, npc        PC write enable and next PC[31:2] (combinational)
//   flush_if/id/ex    pipeline flushes (combinational)
//   pend_valid        a held redirect exists (registered)
//   redirect_cnt      saturating count of applied redirects (registered)
module pc_redirect_sched #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [29:0]      pc,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic             jmp_req,
  input  logic [29:0]      jmp_tgt,
  input  logic             br_req,
  input  logic [29:0]      br_tgt,
  input  logic             exc_req,
  output logic             pc_wr,
  output logic [29:0]      npc,
  output logic             flush_if,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             pend_valid,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam int unsigned PC_W = 30;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  // Encoding order is the priority order, so sources compare numerically.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_JMP  = 2'd1,
    SRC_BR   = 2'd2
`ifdef PC_SCHED_EXC_EN
    ,
    SRC_EXC  = 2'd3
`endif
  } src_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pend_tgt_q, pend_tgt_d;
  src_e             pend_src_q, pend_src_d;
  logic             pend_valid_q, pend_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             blocked;
  src_e             ev_src;
  logic [PC_W-1:0]  ev_tgt;
  src_e             eff_src;
  logic [PC_W-1:0]  eff_tgt;
  src_e             apply_src;
  logic             cnt_inc;
  logic             pc_wr_raw;
  logic [PC_W-1:0]  npc_c;
  logic             unused_ok;

  assign blocked = stall | ~imem_ready;

  // Winning event this cycle; later assignments override earlier ones,
  // giving exc > br > jmp.
  always_comb begin
    ev_src = SRC_NONE;
    ev_tgt = '0;
    if (jmp_req) begin
      ev_src = SRC_JMP;
      ev_tgt = jmp_tgt;
    end
    if (br_req) begin
      ev_src = SRC_BR;
      ev_tgt = br_tgt;
    end
`ifdef PC_SCHED_EXC_EN
    if (exc_req) begin
      ev_src = SRC_EXC;
      ev_tgt = EXC_PC[31:2];
    end
`endif
  end

  // Only a strictly older (higher priority) event may replace the held one.
  always_comb begin
    eff_src = pend_src_q;
    eff_tgt = pend_tgt_q;
    if (ev_src > pend_src_q) begin
      eff_src = ev_src;
      eff_tgt = ev_tgt;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    pend_tgt_d = pend_tgt_q;
    pend_src_d = pend_src_q;
    pc_wr_raw  = 1'b0;
    npc_c      = pc + PC_W'(1);
    apply_src  = SRC_NONE;
    cnt_inc    = 1'b0;

    case (state_q)
      ST_INIT: begin
        pc_wr_raw = 1'b1;
        npc_c     = RESET_PC[31:2];
        state_d   = ST_RUN;
      end

      ST_RUN: begin
        if (ev_src != SRC_NONE) begin
          npc_c = ev_tgt;
          if (!blocked) begin
            pc_wr_raw = 1'b1;
            apply_src = ev_src;
            cnt_inc   = 1'b1;
          end else begin
            pend_tgt_d = ev_tgt;
            pend_src_d = ev_src;
            state_d    = ST_PEND;
          end
        end else begin
          pc_wr_raw = ~blocked;
        end
      end

      ST_PEND: begin
        npc_c      = eff_tgt;
        pend_tgt_d = eff_tgt;
        pend_src_d = eff_src;
        if (!blocked) begin
          pc_wr_raw  = 1'b1;
          apply_src  = eff_src;
          cnt_inc    = 1'b1;
          pend_tgt_d = '0;
          pend_src_d = SRC_NONE;
          state_d    = ST_RUN;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Saturating redirect counter.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign pend_valid_d = (state_d == ST_PEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      pend_tgt_q   <= '0;
      pend_src_q   <= SRC_NONE;
      pend_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pend_tgt_q   <= pend_tgt_d;
      pend_src_q   <= pend_src_d;
      pend_valid_q <= pend_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  // State is INIT during reset; gate the write enable so it reads 0 there.
  assign pc_wr        = pc_wr_raw & rst_n;
  assign npc          = npc_c;
  assign flush_if     = (apply_src != SRC_NONE);
  assign flush_id     = (apply_src >= SRC_BR);
`ifdef PC_SCHED_EXC_EN
  assign flush_ex     = (apply_src == SRC_EXC);
`else
  assign flush_ex     = 1'b0;
`endif
  assign pend_valid   = pend_valid_q;
  assign redirect_cnt = cnt_q;

  // Bits intentionally left unused (byte offsets; exception path when disabled).
`ifdef PC_SCHED_EXC_EN
  assign unused_ok = ^{RESET_PC[1:0], EXC_PC[1:0]};
`else
  assign unused_ok = ^{RESET_PC[1:0], EXC_PC, exc_req};
`endif

endmodule

// File: tb/tb_pc_redirect_sched.sv
module tb_pc_redirect_sched;

`ifdef PC_SCHED_EXC_EN
  localparam bit EXC_ON = 1'b1;
`else
  localparam bit EXC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [29:0] pc = '0;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b1;
  logic        jmp_req = 1'b0;
  logic [29:0] jmp_tgt = '0;
  logic        br_req = 1'b0;
  logic [29:0] br_tgt = '0;
  logic        exc_req = 1'b0;

  logic        pc_wr, flush_if, flush_id, flush_ex, pend_valid;
  logic [29:0] npc;
  logic [15:0] redirect_cnt;

  logic        s_pc_wr, s_flush_if, s_flush_id, s_flush_ex, s_pend_valid;
  logic [29:0] s_npc;
  logic [2:0]  s_cnt;

  always #5 clk = ~clk;

  pc_redirect_sched u_dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .stall(stall), .imem_ready(imem_ready),
    .jmp_req(jmp_req), .jmp_tgt(jmp_tgt), .br_req(br_req), .br_tgt(br_tgt),
    .exc_req(exc_req), .pc_wr(pc_wr), .npc(npc), .flush_if(flush_if),
    .flush_id(flush_id), .flush_ex(flush_ex), .pend_valid(pend_valid),
    .redirect_cnt(redirect_cnt)
  );

  // Narrow-counter copy on the same stimulus to reach saturation quickly.
  pc_redirect_sched #(.CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .pc(pc), .stall(stall), .imem_ready(imem_ready),
    .jmp_req(jmp_req), .jmp_tgt(jmp_tgt), .br_req(br_req), .br_tgt(br_tgt),
    .exc_req(exc_req), .pc_wr(s_pc_wr), .npc(s_npc), .flush_if(s_flush_if),
    .flush_id(s_flush_id), .flush_ex(s_flush_ex), .pend_valid(s_pend_valid),
    .redirect_cnt(s_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [29:0] pc;
    logic        stall;
    logic        rdy;
    logic        jr;
    logic [29:0] jt;
    logic        br;
    logic [29:0] bt;
    logic        er;
    logic        pw;
    logic [29:0] npc;
    logic        cn;   // npc is checked only when set
    logic [2:0]  fl;   // {flush_if, flush_id, flush_ex}
    logic        pv;   // pend_valid after the edge
    logic [15:0] cnt;  // redirect_cnt after the edge
  } vec_t;

  function automatic vec_t mk(
    input logic [29:0] pc_i, input logic st, input logic rd,
    input logic jr, input logic [29:0] jt, input logic br, input logic [29:0] bt,
    input logic er, input logic pw, input logic [29:0] np, input logic cn,
    input logic [2:0] fl, input logic pv, input int cnt);
    vec_t v;
    v.pc = pc_i; v.stall = st; v.rdy = rd; v.jr = jr; v.jt = jt; v.br = br;
    v.bt = bt; v.er = er; v.pw = pw; v.npc = np; v.cn = cn; v.fl = fl;
    v.pv = pv; v.cnt = 16'(cnt);
    return v;
  endfunction

  vec_t vt[20];

  task automatic apply(input vec_t v);
    pc = v.pc; stall = v.stall; imem_ready = v.rdy;
    jmp_req = v.jr; jmp_tgt = v.jt; br_req = v.br; br_tgt = v.bt; exc_req = v.er;
  endtask

  initial begin
    int e;
    e = int'(EXC_ON);
    //        pc           st rd jr jt       br bt       er pw npc                          cn fl                     pv cnt
    vt[0]  = mk(30'h0C00,  1, 1, 1, 30'hE00, 1, 30'hD10, 0, 1, 30'h0C00,                    1, 3'b000,                0, 0);
    vt[1]  = mk(30'h0C00,  0, 1, 0, 30'h0,   0, 30'h0,   0, 1, 30'h0C01,                    1, 3'b000,                0, 0);
    vt[2]  = mk(30'h0C01,  0, 1, 0, 30'h0,   0, 30'h0,   0, 1, 30'h0C02,                    1, 3'b000,                0, 0);
    vt[3]  = mk(30'h0C02,  0, 1, 1, 30'hE00, 1, 30'hD10, 0, 1, 30'h0D10,                    1, 3'b110,                0, 1);
    vt[4]  = mk(30'h0D10,  1, 1, 0, 30'h0,   0, 30'h0,   0, 0, 30'h0D11,                    1, 3'b000,                0, 1);
    vt[5]  = mk(30'h0D10,  1, 1, 1, 30'hE00, 0, 30'h0,   0, 0, 30'h0,                       0, 3'b000,                1, 1);
    vt[6]  = mk(30'h0D10,  1, 1, 1, 30'hE00, 0, 30'h0,   0, 0, 30'h0,                       0, 3'b000,                1, 1);
    vt[7]  = mk(30'h0D10,  1, 1, 0, 30'h0,   0, 30'h0,   0, 0, 30'h0,                       0, 3'b000,                1, 1);
    vt[8]  = mk(30'h0D10,  0, 1, 0, 30'h0,   0, 30'h0,   0, 1, 30'h0E00,                    1, 3'b100,                0, 2);
    vt[9]  = mk(30'h0E00,  0, 1, 0, 30'h0,   0, 30'h0,   0, 1, 30'h0E01,                    1, 3'b000,                0, 2);
    vt[10] = mk(30'h0E01,  0, 0, 1, 30'hE00, 0, 30'h0,   0, 0, 30'h0,                       0, 3'b000,                1, 2);
    vt[11] = mk(30'h0E01,  0, 0, 0, 30'h0,   1, 30'hD20, 0, 0, 30'h0,                       0, 3'b000,                1, 2);
    vt[12] = mk(30'h0E01,  0, 1, 0, 30'h0,   0, 30'h0,   0, 1, 30'h0D20,                    1, 3'b110,                0, 3);
    vt[13] = mk(30'h3FFF_FFFF, 0, 1, 0, 30'h0, 0, 30'h0, 0, 1, 30'h0,                       1, 3'b000,                0, 3);
    vt[14] = mk(30'h0D20,  0, 1, 0, 30'h0,   1, 30'hD30, 1, 1, EXC_ON ? 30'h1060 : 30'h0D30, 1, EXC_ON ? 3'b111 : 3'b110, 0, 4);
    vt[15] = mk(30'h1060,  0, 1, 0, 30'h0,   0, 30'h0,   1, 1, EXC_ON ? 30'h1060 : 30'h1061, 1, EXC_ON ? 3'b111 : 3'b000, 0, 4 + e);
    vt[16] = mk(30'h1061,  1, 1, 0, 30'h0,   1, 30'hD40, 0, 0, 30'h0,                       0, 3'b000,                1, 4 + e);
    vt[17] = mk(30'h1061,  0, 1, 1, 30'hE80, 0, 30'h0,   0, 1, 30'h0D40,                    1, 3'b110,                0, 5 + e);
    vt[18] = mk(30'h0D40,  1, 1, 1, 30'hE90, 0, 30'h0,   0, 0, 30'h0,                       0, 3'b000,                1, 5 + e);
    vt[19] = mk(30'h0D40,  0, 1, 0, 30'h0,   1, 30'hD50, 0, 1, 30'h0D50,                    1, 3'b110,                0, 6 + e);

    // Reset state
    pc = 30'h0C00;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst pc_wr", 32'(pc_wr), 32'd0);
    chk("rst npc", 32'(npc), 32'h0C00);
    chk("rst flush", 32'({flush_if, flush_id, flush_ex}), 32'd0);
    chk("rst pend_valid", 32'(pend_valid), 32'd0);
    chk("rst cnt", 32'(redirect_cnt), 32'd0);
    rst_n = 1'b1;

    // Table: first vector lands in the INIT cycle
    for (int i = 0; i < 20; i++) begin
      apply(vt[i]);
      @(negedge clk);
      chk($sformatf("v%0d pc_wr", i), 32'(pc_wr), 32'(vt[i].pw));
      if (vt[i].cn) chk($sformatf("v%0d npc", i), 32'(npc), 32'(vt[i].npc));
      chk($sformatf("v%0d flush", i), 32'({flush_if, flush_id, flush_ex}), 32'(vt[i].fl));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d pend_valid", i), 32'(pend_valid), 32'(vt[i].pv));
      chk($sformatf("v%0d cnt", i), 32'(redirect_cnt), 32'(vt[i].cnt));
    end

    // Counter saturation: three more unblocked jumps
    pc = 30'h0D50; stall = 1'b0; imem_ready = 1'b1; br_req = 1'b0; exc_req = 1'b0;
    jmp_req = 1'b1; jmp_tgt = 30'h0F00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("sat%0d flush", k), 32'({flush_if, flush_id, flush_ex}), 32'b100);
      @(posedge clk);
      #1;
    end
    chk("sat main cnt", 32'(redirect_cnt), 32'(9 + e));
    chk("sat narrow cnt", 32'(s_cnt), 32'd7);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("sat narrow hold", 32'(s_cnt), 32'd7);

    // Async reset while a redirect is held
    stall = 1'b1; jmp_tgt = 30'h0F40;
    @(posedge clk);
    #1;
    chk("pend before rst", 32'(pend_valid), 32'd1);
    jmp_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst pend_valid", 32'(pend_valid), 32'd0);
    chk("async rst pc_wr", 32'(pc_wr), 32'd0);
    chk("async rst npc", 32'(npc), 32'h0C00);
    chk("async rst cnt", 32'(redirect_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
